// File: rtl/bcd_score_counter.sv
// BCD up/down score register with a two-press confirmed clear for the button front-end.
// Optional armed_blink indicator: define BCD_SCORE_BLINK_EN.
module bcd_score_counter #(
  parameter int NUM_DIGITS     = 2,
  parameter int WRAP           = 0,
  parameter int CONFIRM_CYCLES = 50000000
`ifdef BCD_SCORE_BLINK_EN
  , parameter int BLINK_HALF   = 12500000
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    inc_pulse,
  input  logic                    dec_pulse,
  input  logic                    clr_pulse,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic                    armed,
  output logic                    at_zero,
  output logic                    at_max,
  output logic                    changed
`ifdef BCD_SCORE_BLINK_EN
  , output logic                  armed_blink
`endif
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int TW = $clog2(CONFIRM_CYCLES);
  localparam logic [W-1:0]  ALL_NINES  = {NUM_DIGITS{4'h9}};
  localparam logic [TW-1:0] TIMER_LAST = TW'(CONFIRM_CYCLES - 1);

  typedef enum logic {IDLE, ARMED} stateE;

  stateE         state, stateNext;
  logic [W-1:0]  scoreNext, incValue, decValue, stepValue;
  logic [TW-1:0] timer, timerNext;
  logic          carry, borrow, wantInc, wantDec;

  assign at_zero = (score == '0);
  assign at_max  = (score == ALL_NINES);
  assign armed   = (state == ARMED);

  // Ripple +1 / -1 across the digits; a digit never leaves 0..9.
  // NOTE: blocking '=' here because carry/borrow must ripple digit by digit within one
  // evaluation; registers below use '<=' so every flop samples the pre-edge values.
  always_comb begin
    incValue = score;
    decValue = score;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (score[4*i +: 4] == 4'd9) incValue[4*i +: 4] = 4'd0;
        else begin
          incValue[4*i +: 4] = score[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (score[4*i +: 4] == 4'd0) decValue[4*i +: 4] = 4'd9;
        else begin
          decValue[4*i +: 4] = score[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // inc and dec together cancel; saturation holds unless wrapping is enabled.
  assign wantInc = inc_pulse & ~dec_pulse;
  assign wantDec = dec_pulse & ~inc_pulse;

  always_comb begin
    stepValue = score;
    if (wantInc && !(at_max && WRAP == 0))       stepValue = incValue;
    else if (wantDec && !(at_zero && WRAP == 0)) stepValue = decValue;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    stateNext = state;
    scoreNext = score;
    timerNext = '0;
    case (state)
      IDLE: begin
        if (clr_pulse) stateNext = ARMED;
        else           scoreNext = stepValue;
      end
      ARMED: begin
        if (clr_pulse) begin
          scoreNext = '0;
          stateNext = IDLE;
        end else if (inc_pulse || dec_pulse) begin
          scoreNext = stepValue;
          stateNext = IDLE;
        end else if (timer == TIMER_LAST) begin
          stateNext = IDLE;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      score   <= '0;
      timer   <= '0;
      changed <= 1'b0;
    end else begin
      state   <= stateNext;
      score   <= scoreNext;
      timer   <= timerNext;
      changed <= (scoreNext != score);
    end
  end

`ifdef BCD_SCORE_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blinkCnt;

  // Starts high on entry to ARMED, toggles every BLINK_HALF cycles, dark otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blinkCnt    <= '0;
      armed_blink <= 1'b0;
    end else if (stateNext == ARMED) begin
      if (state == IDLE) begin
        blinkCnt    <= '0;
        armed_blink <= 1'b1;
      end else if (blinkCnt == BLINK_LAST) begin
        blinkCnt    <= '0;
        armed_blink <= ~armed_blink;
      end else begin
        blinkCnt    <= blinkCnt + 1'b1;
      end
    end else begin
      blinkCnt    <= '0;
      armed_blink <= 1'b0;
    end
  end
`endif

endmodule
